// File: rtl/masked_sram_1r1w_init_if.sv
// Read/write request bus of the 1R1W masked memory, plus its init-complete flag.
// Latency: none, this is pure wiring.
// Backpressure: none; requests are only honoured while init_done is high.
interface masked_sram_1r1w_init_if #(
    parameter int AW       = 8,
    parameter int WIDTH    = 24,
    parameter int MASK_SEG = 4
);
    logic                R0_en;
    logic [AW-1:0]       R0_addr;
    logic [WIDTH-1:0]    R0_data;
    logic                R0_valid;
    logic                W0_en;
    logic [AW-1:0]       W0_addr;
    logic [WIDTH-1:0]    W0_data;
    logic [MASK_SEG-1:0] W0_mask;
    logic                init_done;

    // Requester side
    modport master (
        output R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask,
        input  R0_data, R0_valid, init_done
    );

    // Memory side
    modport slave (
        input  R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask,
        output R0_data, R0_valid, init_done
    );
endinterface

// File: rtl/masked_sram_1r1w_init.sv
// 1R1W masked memory that zeroes itself after reset, with a read-during-write bypass and valid-tagged read data.
// Latency: read data is valid READ_LATENCY (1 or 2) cycles after the request; the clear takes DEPTH cycles after reset.
// Backpressure: none; requests made before init_done is high are dropped, and reads are pipelined at one per cycle.
module masked_sram_1r1w_init #(
    parameter int DEPTH        = 256,
    parameter int WIDTH        = 24,
    parameter int MASK_SEG     = 4,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    masked_sram_1r1w_init_if.slave   mem
);

    localparam int            GRAN     = WIDTH / MASK_SEG;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    // One bit wider than the address so that DEPTH == 2**AW still compares correctly
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    if (WIDTH % MASK_SEG != 0) begin : g_bad_mask
        $error("masked_sram_1r1w_init: WIDTH must be a multiple of MASK_SEG");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("masked_sram_1r1w_init: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     init_ptr_q, init_ptr_d;
    logic [WIDTH-1:0]  ram_q [DEPTH];

    logic              ready;
    logic              rd_in_range, wr_in_range;
    logic              rd_acc, wr_acc;
    logic [WIDTH-1:0]  rd_word;

    // Stage 1 of the read pipeline always exists
    logic              rd_vld1_q;
    logic [WIDTH-1:0]  rd_dat1_q;

    assign ready         = (state_q == READY);
    assign mem.init_done = ready;

    // Out-of-range addresses can only occur when DEPTH is not a power of two
    assign rd_in_range = ({1'b0, mem.R0_addr} < DEPTH_W);
    assign wr_in_range = ({1'b0, mem.W0_addr} < DEPTH_W);
    assign rd_acc      = ready && mem.R0_en;
    assign wr_acc      = ready && mem.W0_en && wr_in_range;

    // Clear sequencer: walk every entry once, then stay READY until the next reset
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            INIT: begin
                if (init_ptr_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    init_ptr_d = init_ptr_q + AW'(1);
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // Sequencer state; reset restarts the clear from entry 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Array write port: the clear owns it during INIT, masked user writes afterwards
    always_ff @(posedge clock) begin
        if (!ready) begin
            ram_q[init_ptr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < MASK_SEG; i++) begin
                if (mem.W0_mask[i]) begin
                    ram_q[mem.W0_addr][i*GRAN +: GRAN] <= mem.W0_data[i*GRAN +: GRAN];
                end
            end
        end
    end

    // Read word: old contents, optionally overlaid by the masked segments of a same-address write
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = ram_q[mem.R0_addr];
            if (BYPASS != 0 && wr_acc && mem.W0_addr == mem.R0_addr) begin
                for (int i = 0; i < MASK_SEG; i++) begin
                    if (mem.W0_mask[i]) begin
                        rd_word[i*GRAN +: GRAN] = mem.W0_data[i*GRAN +: GRAN];
                    end
                end
            end
        end
    end

    // First read stage: data only moves on an accepted read so the output holds between reads
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_vld1_q <= 1'b0;
            rd_dat1_q <= '0;
        end else begin
            rd_vld1_q <= rd_acc;
            if (rd_acc) begin
                rd_dat1_q <= rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic             rd_vld2_q;
        logic [WIDTH-1:0] rd_dat2_q;

        // Extra output register stage, again holding data while idle
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                rd_vld2_q <= 1'b0;
                rd_dat2_q <= '0;
            end else begin
                rd_vld2_q <= rd_vld1_q;
                if (rd_vld1_q) begin
                    rd_dat2_q <= rd_dat1_q;
                end
            end
        end

        assign mem.R0_valid = rd_vld2_q;
        assign mem.R0_data  = rd_dat2_q;
    end else begin : g_lat1
        assign mem.R0_valid = rd_vld1_q;
        assign mem.R0_data  = rd_dat1_q;
    end

endmodule

// File: tb/tb_masked_sram_1r1w_init.sv
// Bench for masked_sram_1r1w_init: two builds (256 deep, latency 1, bypass) and (200 deep, latency 2, no bypass)
// Both see identical stimulus; a per-cycle reference model plus a few fixed spot values judge them.
// Inputs change 1 time unit after each rising edge and outputs are compared at that same point.
module tb_masked_sram_1r1w_init;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    logic        r_en, w_en;
    logic [7:0]  r_addr, w_addr;
    logic [23:0] w_data;
    logic [3:0]  w_mask;

    masked_sram_1r1w_init_if #(.AW(8), .WIDTH(24), .MASK_SEG(4)) bus_a ();
    masked_sram_1r1w_init_if #(.AW(8), .WIDTH(24), .MASK_SEG(4)) bus_b ();

    assign bus_a.R0_en   = r_en;
    assign bus_a.R0_addr = r_addr;
    assign bus_a.W0_en   = w_en;
    assign bus_a.W0_addr = w_addr;
    assign bus_a.W0_data = w_data;
    assign bus_a.W0_mask = w_mask;
    assign bus_b.R0_en   = r_en;
    assign bus_b.R0_addr = r_addr;
    assign bus_b.W0_en   = w_en;
    assign bus_b.W0_addr = w_addr;
    assign bus_b.W0_data = w_data;
    assign bus_b.W0_mask = w_mask;

    masked_sram_1r1w_init #(
        .DEPTH(256), .WIDTH(24), .MASK_SEG(4), .READ_LATENCY(1), .BYPASS(1)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .mem   (bus_a)
    );

    masked_sram_1r1w_init #(
        .DEPTH(200), .WIDTH(24), .MASK_SEG(4), .READ_LATENCY(2), .BYPASS(0)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .mem   (bus_b)
    );

    // Reference model: expected reads are queued with the cycle they must appear in
    typedef struct {
        int          due;
        logic [23:0] val;
    } rd_t;

    rd_t         qa[$];
    rd_t         qb[$];
    logic [23:0] mdl [2][256];
    logic [23:0] last [2];
    int          depth [2] = '{256, 200};
    int          lat   [2] = '{1, 2};
    int          byp   [2] = '{1, 0};
    int          cyc;
    bit          in_rst;
    int          checks;
    int          errors;

    function automatic logic [23:0] merge(input logic [23:0] old, input logic [23:0] nw,
                                          input logic [3:0] m);
        logic [23:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[i*6 +: 6] = nw[i*6 +: 6];
        end
        return r;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        last[0] = '0;
        last[1] = '0;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) mdl[k][a] = '0;
        end
    endtask

    // What each build does at one rising edge, given the inputs held during the cycle
    task automatic model_edge();
        rd_t e;
        for (int k = 0; k < 2; k++) begin
            if (!in_rst && cyc >= depth[k]) begin
                if (r_en) begin
                    e.due = cyc + lat[k];
                    if (int'(r_addr) >= depth[k])
                        e.val = '0;
                    else if (byp[k] != 0 && w_en && w_addr == r_addr)
                        e.val = merge(mdl[k][r_addr], w_data, w_mask);
                    else
                        e.val = mdl[k][r_addr];
                    if (k == 0) qa.push_back(e);
                    else        qb.push_back(e);
                end
                if (w_en && int'(w_addr) < depth[k]) begin
                    mdl[k][w_addr] = merge(mdl[k][w_addr], w_data, w_mask);
                end
            end
        end
    endtask

    task automatic check_one(input int k, input logic v, input logic [23:0] d, input logic id);
        logic ev;
        logic eid;
        rd_t  e;
        ev = 1'b0;
        if (k == 0) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                e  = qa.pop_front();
                ev = 1'b1;
            end
        end else begin
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e  = qb.pop_front();
                ev = 1'b1;
            end
        end
        if (ev) last[k] = e.val;
        eid = !in_rst && (cyc >= depth[k]);

        checks++;
        assert (v === ev) else begin
            errors++;
            $error("FAIL valid[%0d] cyc %0d got %b exp %b", k, cyc, v, ev);
        end
        checks++;
        assert (d === last[k]) else begin
            errors++;
            $error("FAIL data[%0d] cyc %0d got %h exp %h", k, cyc, d, last[k]);
        end
        checks++;
        assert (id === eid) else begin
            errors++;
            $error("FAIL init_done[%0d] cyc %0d got %b exp %b", k, cyc, id, eid);
        end
    endtask

    task automatic spot(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Check this cycle's outputs, then advance over one rising edge
    task automatic tick();
        check_one(0, bus_a.R0_valid, bus_a.R0_data, bus_a.init_done);
        check_one(1, bus_b.R0_valid, bus_b.R0_data, bus_b.init_done);
        @(posedge clock);
        model_edge();
        if (!in_rst) cyc++;
        #1;
    endtask

    task automatic drive(input logic ren, input logic [7:0] ra, input logic wen,
                         input logic [7:0] wa, input logic [23:0] wd, input logic [3:0] wm);
        r_en   = ren;
        r_addr = ra;
        w_en   = wen;
        w_addr = wa;
        w_data = wd;
        w_mask = wm;
    endtask

    task automatic step(input logic ren, input logic [7:0] ra, input logic wen,
                        input logic [7:0] wa, input logic [23:0] wd, input logic [3:0] wm);
        drive(ren, ra, wen, wa, wd, wm);
        tick();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 8'h0, 1'b0, 8'h0, 24'h0, 4'h0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset is asserted asynchronously, held three edges, released just after an edge (edge 0 follows)
    task automatic apply_reset();
        reset  = 1'b0;
        in_rst = 1'b1;
        cyc    = 0;
        model_clear();
        #1;
        for (int i = 0; i < 3; i++) tick();
        reset  = 1'b1;
        in_rst = 1'b0;
        cyc    = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra;
        checks = 0;
        errors = 0;
        in_rst = 1'b0;
        cyc    = 0;
        model_clear();
        drive(1'b0, 8'h0, 1'b0, 8'h0, 24'h0, 4'h0);
        @(posedge clock);
        #1;
        apply_reset();

        // Clear phase with both enables held high and random traffic from cycle 0
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 8'($urandom), 24'($urandom), 4'($urandom));
        end
        // Cycle 256: the 256-deep build has just become ready
        step(1'b1, 8'd0,   1'b0, 8'd0, 24'h0, 4'h0);
        step(1'b1, 8'd128, 1'b0, 8'd0, 24'h0, 4'h0);
        step(1'b1, 8'd255, 1'b0, 8'd0, 24'h0, 4'h0);
        idle(3);
        spot("clear_rd_a", bus_a.R0_data, 24'h000000);

        // Masked write: seg0 <- 0x16, seg2 <- 0x23, seg1/seg3 keep 0x3F  =>  0xFE3FD6
        step(1'b0, 8'd0, 1'b1, 8'd5, 24'hFFFFFF, 4'b1111);
        step(1'b0, 8'd0, 1'b1, 8'd5, 24'h123456, 4'b0101);
        step(1'b1, 8'd5, 1'b0, 8'd0, 24'h0, 4'h0);
        idle(3);
        spot("mask_a", bus_a.R0_data, 24'hFE3FD6);
        spot("mask_b", bus_b.R0_data, 24'hFE3FD6);

        // Same-cycle read/write of address 9
        step(1'b0, 8'd0, 1'b1, 8'd9, 24'h000000, 4'b1111);
        step(1'b1, 8'd9, 1'b1, 8'd9, 24'hABCDEF, 4'b0011);
        idle(1);
        spot("bypass_a", bus_a.R0_data, 24'h000DEF);
        spot("nobypass_b", bus_b.R0_data, 24'h000000);
        step(1'b1, 8'd9, 1'b0, 8'd0, 24'h0, 4'h0);
        idle(3);
        spot("after_wr_a", bus_a.R0_data, 24'h000DEF);
        spot("after_wr_b", bus_b.R0_data, 24'h000DEF);

        // Back-to-back reads through the two-stage build
        step(1'b0, 8'd0, 1'b1, 8'd1, 24'h000011, 4'b1111);
        step(1'b0, 8'd0, 1'b1, 8'd2, 24'h000022, 4'b1111);
        step(1'b0, 8'd0, 1'b1, 8'd3, 24'h000033, 4'b1111);
        step(1'b1, 8'd1, 1'b0, 8'd0, 24'h0, 4'h0);
        step(1'b1, 8'd2, 1'b0, 8'd0, 24'h0, 4'h0);
        step(1'b1, 8'd3, 1'b0, 8'd0, 24'h0, 4'h0);
        idle(3);
        spot("pipe_hold_b", bus_b.R0_data, 24'h000033);
        spot("pipe_idle_b", {23'h0, bus_b.R0_valid}, 24'h000000);

        // Reset while a read is in flight, then a full clear
        step(1'b0, 8'd0, 1'b1, 8'd7, 24'h5A5A5A, 4'b1111);
        step(1'b1, 8'd7, 1'b0, 8'd0, 24'h0, 4'h0);
        drive(1'b0, 8'h0, 1'b0, 8'h0, 24'h0, 4'h0);
        apply_reset();
        idle(256);
        step(1'b1, 8'd7, 1'b0, 8'd0, 24'h0, 4'h0);
        idle(3);
        spot("rst_clear_a", bus_a.R0_data, 24'h000000);
        spot("rst_clear_b", bus_b.R0_data, 24'h000000);

        // Address 210 lies beyond the 200-deep build
        step(1'b0, 8'd0,   1'b1, 8'd210, 24'h777777, 4'b1111);
        step(1'b0, 8'd0,   1'b1, 8'd10,  24'h777777, 4'b1111);
        step(1'b1, 8'd10,  1'b0, 8'd0,   24'h0, 4'h0);
        step(1'b1, 8'd210, 1'b0, 8'd0,   24'h0, 4'h0);
        idle(3);
        spot("oor_a", bus_a.R0_data, 24'h777777);
        spot("oor_b", bus_b.R0_data, 24'h000000);

        // Random traffic with frequent same-address collisions
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            step(1'($urandom), ra, 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? ra : 8'($urandom),
                 24'($urandom), 4'($urandom));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
